ulpi_phy_model: RTL and testbench
=================================

ULPI_PHY_MODEL -- requirements
Module: ulpi_phy_model

Interface
REQ-001 SHALL have parameters: VENDOR_ID, 16'h0424, reported at regs 0x00/0x01 (LSB first); PRODUCT_ID, 16'h0009, reported at regs 0x02/0x03; RST_HOLD, 8, number of cycles DIR is held high for power-up and UTMI reset.
REQ-002 SHALL use one clock and a synchronous active-high reset: CLK_60M in 1, 60 MHz ULPI clock, all logic on its rising edge; RST_USB in 1, synchronous active-high reset.
REQ-003 SHALL have ports: USB_DATA_IN in 8, link-driven bus value; USB_DATA_OUT out 8, PHY-driven bus value; USB_DATA_OE out 1, PHY drives the bus when 1.
REQ-004 SHALL have ports: USB_DIR out 1, ULPI DIR; USB_NXT out 1, ULPI NXT; USB_STP in 1, ULPI STP; LINESTATE in 2, emulated line state.
REQ-005 SHALL have ports: RX_DATA in 8, packet byte to send to the link; RX_VALID in 1, byte valid; RX_LAST in 1, final byte of the packet; RX_ERROR in 1, flag the packet as errored; RX_READY out 1, byte consumed when RX_VALID&RX_READY.
REQ-006 SHALL have ports: TX_PID out 4, PID from TXCMD; TX_START out 1, pulse; TX_DATA out 8, byte captured from the link; TX_VALID out 1, pulse per byte; TX_END out 1, pulse on STP.

Function
REQ-007 SHALL register every output; USB_DATA_OE=0 whenever USB_DIR=0.
REQ-008 SHALL sample a TXCMD only in IDLE with DIR low on both the current and previous cycle; 8'h00 is NOOP; decode [7:6]: 01 transmit, 10 reg write, 11 reg read; 00 with nonzero value is ignored.
REQ-009 SHALL give priority in IDLE as TXCMD > RX packet (RX_VALID) > pending RXCMD (LINESTATE differs from last reported value).
REQ-010 Reg write, TXCMD sampled at cycle T: NXT=1 in T+1 (cmd accepted) and in T+2 (data sampled); NXT=0 from T+3; commit when STP=1, then IDLE.
REQ-011 Reg write SHALL abort with no commit if STP=1 during T+1 or T+2.
REQ-012 Reg read, TXCMD at T: NXT=1 in T+1; T+2 DIR=1, OE=0 (turnaround); T+3 DIR=1, OE=1, USB_DATA_OUT=reg[addr], NXT=0; T+4 DIR=0; then IDLE.
REQ-013 Register file SHALL be 16 bytes at 0x00-0x0F: 0x00-0x03 read-only IDs, writes to them ignored; addresses 0x10-0x3F ignore writes and read 8'h00.
REQ-014 A write to 0x04 with bit5=1 SHALL store the value with bit5 cleared, then hold DIR=1 (OE=0) for RST_HOLD cycles, then DIR=0, then IDLE.
REQ-015 Transmit, TXCMD at T: TX_PID=TXCMD[3:0] and TX_START pulse at T+1; NXT=1 from T+1 until STP.
REQ-016 Transmit SHALL, from T+2 onward, pulse TX_VALID with TX_DATA=USB_DATA_IN on each cycle with STP=0; on the STP=1 cycle, pulse TX_END, capture no byte, NXT=0, and return to IDLE.
REQ-017 An RX packet SHALL run: turnaround cycle DIR=1, OE=0, NXT=0; then per cycle, if RX_VALID, drive RX_DATA with NXT=1 and RX_READY=1; else drive RXCMD with NXT=0.
REQ-018 After the byte with RX_LAST, an RX packet SHALL drive one RXCMD with RxEvent=00, then one turnaround cycle DIR=0, then IDLE.
REQ-019 RXCMD byte SHALL be {2'b00, RxEvent[1:0], 2'b11, LINESTATE}; RxEvent=01 while a packet is active, 11 if RX_ERROR was seen in the packet, 00 otherwise.
REQ-020 A standalone RXCMD SHALL be 3 cycles: DIR=1 OE=0; DIR=1 OE=1 driving RXCMD, NXT=0; DIR=0. The last-reported LINESTATE SHALL update on the drive cycle.
REQ-021 STP while DIR=1 SHALL be ignored; TXCMD bytes present while DIR=1 or on the first cycle after DIR falls SHALL be ignored.

Reset
REQ-022 With RST_USB high: outputs 0, DIR=0, last LINESTATE=2'b00, regs 0x04=8'h41 and others 8'h00 (IDs per parameters).
REQ-023 After RST_USB falls: DIR=1, OE=0 for RST_HOLD cycles, then DIR=0, then IDLE; RST_USB mid-operation aborts immediately, no partial write.

Verification
REQ-024 Read 0x00 (TXCMD 8'hC0) -> NXT at T+1, DIR at T+2, bus=8'h24 at T+3, DIR low at T+4.
REQ-025 Write 0x16<-8'h5A, STP at T+3 -> reg 0x16 ignored (reads 8'h00); write 0x07<-8'h5A then read 0x07 -> 8'h5A.
REQ-026 Write 0x04<-8'h61 -> DIR high 8 cycles, then read 0x04 -> 8'h41.
REQ-027 TXCMD 8'h43, bytes 8'h11, 8'h22, STP -> TX_PID=3, two TX_VALID (11,22), one TX_END, no byte on STP cycle.
REQ-028 RX packet 8'hC3, gap, 8'hAA last, RX_ERROR=0 -> DIR, C3/NXT, RXCMD 8'h1C|LS, AA/NXT, RXCMD 8'h0C|LS, DIR low.
REQ-029 LINESTATE 00->01 in IDLE -> 3-cycle RXCMD with 8'h0D; simultaneous TXCMD wins and RXCMD follows after return to IDLE.

Source files
------------

// File: rtl/ulpi_phy_model.sv
// ULPI PHY behavioural model: decodes link TXCMDs (transmit, register
// write, register read), streams RX packets and RXCMDs to the link, and
// emulates the power-up / UTMI-reset DIR hold. All outputs are registered.
//
// RX handshake: a byte is consumed on the rising edge where
// RX_VALID && RX_READY. RX_DATA/RX_LAST/RX_ERROR must stay stable until
// that edge. RX_READY is registered, so it rises in the cycle the byte is
// already on the ULPI bus and never stays high for two cycles in a row.
module ulpi_phy_model #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009,
  parameter int          RST_HOLD   = 8
) (
  input  logic       CLK_60M,
  input  logic       RST_USB,
  input  logic [7:0] USB_DATA_IN,
  output logic [7:0] USB_DATA_OUT,
  output logic       USB_DATA_OE,
  output logic       USB_DIR,
  output logic       USB_NXT,
  input  logic       USB_STP,
  input  logic [1:0] LINESTATE,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_LAST,
  input  logic       RX_ERROR,
  output logic       RX_READY,
  output logic [3:0] TX_PID,
  output logic       TX_START,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  output logic       TX_END,
  output logic [3:0] DBG_STATE
);

  typedef enum logic [3:0] {
    ST_PWRUP, ST_HOLD, ST_TURN_END, ST_IDLE,
    ST_WR_ADDR, ST_WR_DATA, ST_WR_WAIT,
    ST_RD_NXT, ST_RD_TURN, ST_RD_DATA,
    ST_TX_FIRST, ST_TX_DATA,
    ST_RX_ACTIVE, ST_RX_EOP,
    ST_CMD_TURN, ST_CMD_DRIVE
  } state_t;

  localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic [1:0]  last_ls_q, last_ls_d;
  logic        rx_err_q, rx_err_d;
  logic        rx_last_q, rx_last_d;
  logic        dir_prev_q;

  logic [7:0]  data_out_q, data_out_d;
  logic        oe_q, oe_d;
  logic        dir_q, dir_d;
  logic        nxt_q, nxt_d;
  logic        rx_ready_q, rx_ready_d;
  logic [3:0]  tx_pid_q, tx_pid_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_end_q, tx_end_d;

  logic [7:0]  rd_byte;
  logic        wr_ok;
  logic        cmd_ok;

  function automatic logic [7:0] rxcmd(input logic [1:0] ev, input logic [1:0] ls);
    return {2'b00, ev, 2'b11, ls};
  endfunction

  // Register file read port: IDs are constants, 0x10-0x3F read as zero.
  always_comb begin
    rd_byte = 8'h00;
    if (addr_q[5:4] == 2'b00) begin
      case (addr_q[3:0])
        4'h0:    rd_byte = VENDOR_ID[7:0];
        4'h1:    rd_byte = VENDOR_ID[15:8];
        4'h2:    rd_byte = PRODUCT_ID[7:0];
        4'h3:    rd_byte = PRODUCT_ID[15:8];
        default: rd_byte = regs_q[addr_q[3:0]];
      endcase
    end
  end

  assign wr_ok  = (addr_q[5:4] == 2'b00) && (addr_q[3:2] != 2'b00);
  // A TXCMD is only trusted once the bus has been link-owned for two cycles.
  assign cmd_ok = !dir_q && !dir_prev_q && (USB_DATA_IN[7:6] != 2'b00);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    regs_d     = regs_q;
    last_ls_d  = last_ls_q;
    rx_err_d   = rx_err_q;
    rx_last_d  = rx_last_q;
    data_out_d = 8'h00;
    oe_d       = 1'b0;
    dir_d      = 1'b0;
    nxt_d      = 1'b0;
    rx_ready_d = 1'b0;
    tx_pid_d   = tx_pid_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    tx_end_d   = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        dir_d   = 1'b1;
        cnt_d   = HOLD_INIT;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_TURN_END;
        end else begin
          dir_d = 1'b1;
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_TURN_END: state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_ok) begin
          nxt_d  = 1'b1;
          addr_d = USB_DATA_IN[5:0];
          case (USB_DATA_IN[7:6])
            2'b01: begin
              tx_pid_d   = USB_DATA_IN[3:0];
              tx_start_d = 1'b1;
              state_d    = ST_TX_FIRST;
            end
            2'b10:   state_d = ST_WR_ADDR;
            default: state_d = ST_RD_NXT;
          endcase
        end else if (RX_VALID) begin
          dir_d     = 1'b1;
          rx_err_d  = 1'b0;
          rx_last_d = 1'b0;
          state_d   = ST_RX_ACTIVE;
        end else if (LINESTATE != last_ls_q) begin
          dir_d   = 1'b1;
          state_d = ST_CMD_TURN;
        end
      end
      ST_WR_ADDR: begin
        if (USB_STP) begin
          state_d = ST_IDLE;
        end else begin
          nxt_d   = 1'b1;
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (USB_STP) begin
          state_d = ST_IDLE;
        end else begin
          wdata_d = USB_DATA_IN;
          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (USB_STP) begin
          state_d = ST_IDLE;
          if (addr_q == 6'h04 && wdata_q[5]) begin
            // Self-clearing reset bit kicks off a UTMI reset DIR hold.
            regs_d[4] = wdata_q & 8'hDF;
            dir_d     = 1'b1;
            cnt_d     = HOLD_INIT;
            state_d   = ST_HOLD;
          end else if (wr_ok) begin
            regs_d[addr_q[3:0]] = wdata_q;
          end
        end
      end
      ST_RD_NXT: begin
        dir_d   = 1'b1;
        state_d = ST_RD_TURN;
      end
      ST_RD_TURN: begin
        dir_d      = 1'b1;
        oe_d       = 1'b1;
        data_out_d = rd_byte;
        state_d    = ST_RD_DATA;
      end
      ST_RD_DATA: state_d = ST_TURN_END;
      ST_TX_FIRST, ST_TX_DATA: begin
        if (USB_STP) begin
          tx_end_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          nxt_d   = 1'b1;
          state_d = ST_TX_DATA;
          if (state_q == ST_TX_DATA) begin
            tx_valid_d = 1'b1;
            tx_data_d  = USB_DATA_IN;
          end
        end
      end
      ST_RX_ACTIVE: begin
        dir_d = 1'b1;
        oe_d  = 1'b1;
        if (rx_ready_q && rx_last_q) begin
          data_out_d = rxcmd(rx_err_q ? 2'b11 : 2'b00, LINESTATE);
          state_d    = ST_RX_EOP;
        end else if (!rx_ready_q && RX_VALID) begin
          data_out_d = RX_DATA;
          nxt_d      = 1'b1;
          rx_ready_d = 1'b1;
          rx_last_d  = RX_LAST;
          rx_err_d   = rx_err_q | RX_ERROR;
        end else begin
          data_out_d = rxcmd(rx_err_q ? 2'b11 : 2'b01, LINESTATE);
        end
      end
      ST_RX_EOP: state_d = ST_TURN_END;
      ST_CMD_TURN: begin
        dir_d      = 1'b1;
        oe_d       = 1'b1;
        data_out_d = rxcmd(2'b00, LINESTATE);
        last_ls_d  = LINESTATE;
        state_d    = ST_CMD_DRIVE;
      end
      ST_CMD_DRIVE: state_d = ST_TURN_END;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state_q    <= ST_PWRUP;
      cnt_q      <= 16'd0;
      addr_q     <= 6'd0;
      wdata_q    <= 8'h00;
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 4) ? 8'h41 : 8'h00;
      last_ls_q  <= 2'b00;
      rx_err_q   <= 1'b0;
      rx_last_q  <= 1'b0;
      dir_prev_q <= 1'b0;
      data_out_q <= 8'h00;
      oe_q       <= 1'b0;
      dir_q      <= 1'b0;
      nxt_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_pid_q   <= 4'h0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_end_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      regs_q     <= regs_d;
      last_ls_q  <= last_ls_d;
      rx_err_q   <= rx_err_d;
      rx_last_q  <= rx_last_d;
      dir_prev_q <= dir_q;
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      dir_q      <= dir_d;
      nxt_q      <= nxt_d;
      rx_ready_q <= rx_ready_d;
      tx_pid_q   <= tx_pid_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_end_q   <= tx_end_d;
    end
  end

  assign USB_DATA_OUT = data_out_q;
  assign USB_DATA_OE  = oe_q;
  assign USB_DIR      = dir_q;
  assign USB_NXT      = nxt_q;
  assign RX_READY     = rx_ready_q;
  assign TX_PID       = tx_pid_q;
  assign TX_START     = tx_start_q;
  assign TX_DATA      = tx_data_q;
  assign TX_VALID     = tx_valid_q;
  assign TX_END       = tx_end_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_ulpi_phy_model.sv
// Directed bench for ulpi_phy_model: reset hold, register read/write,
// UTMI reset, transmit capture, RX packets and RXCMD arbitration.
module tb_ulpi_phy_model;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       oe, dir, nxt, stp;
  logic [1:0] ls;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last, rx_error, rx_ready;
  logic [3:0] tx_pid;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid, tx_end;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int hold_n;
  logic oe_seen;

  ulpi_phy_model dut (
    .CLK_60M(clk), .RST_USB(rst),
    .USB_DATA_IN(data_in), .USB_DATA_OUT(data_out), .USB_DATA_OE(oe),
    .USB_DIR(dir), .USB_NXT(nxt), .USB_STP(stp), .LINESTATE(ls),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_LAST(rx_last),
    .RX_ERROR(rx_error), .RX_READY(rx_ready),
    .TX_PID(tx_pid), .TX_START(tx_start), .TX_DATA(tx_data),
    .TX_VALID(tx_valid), .TX_END(tx_end), .DBG_STATE(dbg_state)
  );

  // Clock and run-time guard
  always #8 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // Counts consecutive DIR-high cycles starting with the current one.
  task automatic count_dir(output int n);
    n = 0;
    oe_seen = 1'b0;
    while (dir && n < 64) begin
      n++;
      if (oe) oe_seen = 1'b1;
      tick();
    end
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [7:0] exp, input string tag);
    data_in = {2'b11, addr};
    tick();
    check_eq({tag, "_nxt_t1"}, {dir, nxt}, 2'b01);
    tick();
    data_in = 8'h00;
    check_eq({tag, "_turn_t2"}, {dir, oe, nxt}, 3'b100);
    tick();
    check_eq({tag, "_data_t3"}, {dir, oe, nxt, data_out}, {3'b110, exp});
    tick();
    check_eq({tag, "_dirlow_t4"}, {dir, oe}, 2'b00);
    tick();
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [7:0] val, input string tag);
    data_in = {2'b10, addr};
    tick();
    check_eq({tag, "_nxt_t1"}, nxt, 1'b1);
    tick();
    data_in = val;
    check_eq({tag, "_nxt_t2"}, nxt, 1'b1);
    tick();
    check_eq({tag, "_nxt_t3"}, nxt, 1'b0);
    data_in = 8'h00;
    stp = 1'b1;
    tick();
    stp = 1'b0;
  endtask

  // Power-up: reset, DIR hold, then IDLE
  task automatic reset_and_hold(input string tag);
    rst = 1'b1;
    repeat (3) tick();
    check_eq({tag, "_rst_outs"}, {dir, oe, nxt, rx_ready, tx_start, tx_valid, tx_end, data_out},
             16'h0000);
    rst = 1'b0;
    tick();
    count_dir(hold_n);
    check_eq({tag, "_hold_cycles"}, 16'(hold_n), 16'd8);
    check_eq({tag, "_hold_oe"}, oe_seen, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; stp = 1'b0; ls = 2'b00;
    rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0;

    reset_and_hold("pwrup");

    // ID and reset-value reads
    do_read(6'h00, 8'h24, "rd00");
    do_read(6'h01, 8'h04, "rd01");
    do_read(6'h02, 8'h09, "rd02");
    do_read(6'h03, 8'h00, "rd03");
    do_read(6'h04, 8'h41, "rd04");

    // Writes: out-of-range, normal, read-only
    do_write(6'h16, 8'h5A, "wr16");
    do_read(6'h16, 8'h00, "rd16");
    do_write(6'h07, 8'h5A, "wr07");
    do_read(6'h07, 8'h5A, "rd07");
    do_write(6'h00, 8'hFF, "wr00");
    do_read(6'h00, 8'h24, "rd00_ro");

    // Write aborted by STP during T+1
    data_in = 8'h88;
    tick();
    stp = 1'b1;
    tick();
    stp = 1'b0;
    data_in = 8'h33;
    check_eq("abort_nxt", nxt, 1'b0);
    tick();
    data_in = 8'h00;
    tick();
    do_read(6'h08, 8'h00, "rd08_abort");

    // UTMI reset via reg 0x04 bit5
    do_write(6'h04, 8'h61, "wr04");
    count_dir(hold_n);
    check_eq("utmi_hold_cycles", 16'(hold_n), 16'd8);
    check_eq("utmi_hold_oe", oe_seen, 1'b0);
    tick();
    do_read(6'h04, 8'h41, "rd04_utmi");

    // Transmit: PID 3, bytes 11 and 22, then STP
    data_in = 8'h43;
    tick();
    check_eq("tx_start", {tx_start, tx_pid, nxt}, {1'b1, 4'h3, 1'b1});
    tick();
    data_in = 8'h11;
    check_eq("tx_t2", {tx_valid, tx_start, nxt}, 3'b001);
    tick();
    data_in = 8'h22;
    check_eq("tx_byte0", {tx_valid, tx_data}, {1'b1, 8'h11});
    tick();
    data_in = 8'h00;
    stp = 1'b1;
    check_eq("tx_byte1", {tx_valid, tx_data, nxt}, {1'b1, 8'h22, 1'b1});
    tick();
    stp = 1'b0;
    check_eq("tx_end", {tx_end, tx_valid, nxt}, 3'b100);
    tick();
    check_eq("tx_end_pulse", tx_end, 1'b0);

    // RX packet C3, AA(last), no error
    rx_valid = 1'b1; rx_data = 8'hC3; rx_last = 1'b0;
    tick();
    check_eq("rx_turn", {dir, oe, nxt}, 3'b100);
    tick();
    check_eq("rx_c3", {dir, oe, nxt, rx_ready, data_out}, {4'b1111, 8'hC3});
    tick();
    rx_data = 8'hAA; rx_last = 1'b1;
    check_eq("rx_cmd_active", {nxt, rx_ready, data_out}, {2'b00, 8'h1C});
    tick();
    check_eq("rx_aa", {nxt, rx_ready, data_out}, {2'b11, 8'hAA});
    tick();
    rx_valid = 1'b0; rx_last = 1'b0;
    check_eq("rx_cmd_end", {dir, oe, nxt, data_out}, {3'b110, 8'h0C});
    tick();
    check_eq("rx_dirlow", {dir, oe}, 2'b00);
    tick();

    // Single-byte errored packet
    rx_valid = 1'b1; rx_data = 8'h55; rx_last = 1'b1; rx_error = 1'b1;
    tick();
    tick();
    check_eq("rxe_55", {nxt, rx_ready, data_out}, {2'b11, 8'h55});
    tick();
    rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0;
    check_eq("rxe_cmd_end", {dir, oe, data_out}, {2'b11, 8'h3C});
    tick();
    check_eq("rxe_dirlow", dir, 1'b0);
    tick();

    // Standalone RXCMD on LINESTATE change
    ls = 2'b01;
    tick();
    check_eq("ls_turn", {dir, oe, nxt}, 3'b100);
    tick();
    check_eq("ls_drive", {dir, oe, nxt, data_out}, {3'b110, 8'h0D});
    tick();
    data_in = 8'hC0;
    check_eq("ls_dirlow", {dir, oe}, 2'b00);
    tick();
    data_in = 8'h00;
    check_eq("ls_no_repeat", {dir, nxt}, 2'b00);
    tick();
    check_eq("cmd_after_dirfall_ignored", {dir, nxt}, 2'b00);

    // NOOP-class byte ignored
    data_in = 8'h05;
    tick();
    data_in = 8'h00;
    check_eq("ignore_05", {dir, nxt}, 2'b00);
    tick();

    // TXCMD beats a simultaneous LINESTATE change; RXCMD follows
    ls = 2'b10;
    do_read(6'h02, 8'h09, "rd02_prio");
    tick();
    check_eq("prio_ls_turn", {dir, oe}, 2'b10);
    tick();
    check_eq("prio_ls_drive", {dir, oe, data_out}, {2'b11, 8'h0E});
    tick();
    check_eq("prio_ls_dirlow", dir, 1'b0);
    tick();

    // Reset in the middle of a write: nothing committed
    data_in = 8'h87;
    tick();
    tick();
    data_in = 8'h99;
    tick();
    data_in = 8'h00;
    rst = 1'b1;
    tick();
    check_eq("midrst_outs", {dir, nxt, oe}, 3'b000);
    ls = 2'b00;
    reset_and_hold("midrst");
    do_read(6'h07, 8'h00, "rd07_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
